// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state encoding and divisor constants for the clock divider bank
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Smallest divisor that still gives a distinct high and low phase
    localparam int DIV_MIN = 2;

    // Reset divisors at 100 MHz, ch0 in the LSBs: 41667 (ch0), 2604 (ch1), 25000 (ch2)
    localparam logic [47:0] DIV_INIT_DEFAULT = {16'd25000, 16'd2604, 16'd41667};

endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel with shadowed divisor, IDLE/ARM/RUN sequencing and registered outputs
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_MIN)
) (
    input  logic             master_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic             div_pend
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic             apply;

    // Next state: sync acts as a forced wrap; the shadow divisor is taken over at every wrap or while idle
    always_comb begin
        wrap    = sync || (count_q >= act_q - CNT_W'(1));
        apply   = (state_q == IDLE) || (en && wrap);
        shd_d   = wr ? wr_div : shd_q;
        act_d   = apply ? shd_d : act_q;
        pend_d  = !apply && (wr || pend_q);
        tick_d  = en && ((state_q == IDLE) ? sync : wrap);
        state_d = !en ? IDLE : tick_d ? RUN : (state_q == IDLE) ? ARM : state_q;
        count_d = (!en || tick_d) ? '0 : (state_q == IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
        clk_d   = (state_d == RUN) && (count_d < act_d - (act_d >> 1));
    end

    // Channel registers, cleared asynchronously to the reset divisor
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            act_q   <= DIV_RST;
            shd_q   <= DIV_RST;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_out  = clk_q;
    assign tick     = tick_q;
    assign running  = (state_q == RUN);
    assign div_pend = pend_q;

endmodule

// File: rtl/clkdiv_bank.sv
// clkdiv_bank: bank of independent clock dividers sharing one sync pulse and one divisor write port
module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter int                      NUM_CH   = 3,
    parameter int                      CNT_W    = 16,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = (NUM_CH*CNT_W)'(DIV_INIT_DEFAULT),
    localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              master_clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running,
    output logic [NUM_CH-1:0] div_pend
);

    logic [CNT_W-1:0]  wr_val;
    logic [NUM_CH-1:0] wr_sel;

    // Write decode: clamp tiny divisors and drop writes aimed past the last channel
    always_comb begin
        wr_val = (wr_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : wr_div;
        for (int i = 0; i < NUM_CH; i++)
            wr_sel[i] = wr_en && (32'(wr_ch) == i);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clkdiv_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_chan (
            .master_clk (master_clk),
            .reset      (reset),
            .en         (ch_en[i]),
            .sync       (sync),
            .wr         (wr_sel[i]),
            .wr_div     (wr_val),
            .clk_out    (clk_out[i]),
            .tick       (tick[i]),
            .running    (running[i]),
            .div_pend   (div_pend[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_bank.sv
// tb_clkdiv_bank: timestamp-based reference model plus directed and random stimulus for clkdiv_bank
module tb_clkdiv_bank;

    logic        master_clk = 1'b0;
    logic        reset      = 1'b1;
    logic [2:0]  ch_en      = '0;
    logic        sync       = 1'b0;
    logic        wr_en      = 1'b0;
    logic [1:0]  wr_ch      = '0;
    logic [15:0] wr_div     = '0;
    logic [2:0]  clk_out, tick, running, div_pend;

    int tests = 0;
    int fails = 0;

    clkdiv_bank dut (
        .master_clk (master_clk),
        .reset      (reset),
        .ch_en      (ch_en),
        .sync       (sync),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_div     (wr_div),
        .clk_out    (clk_out),
        .tick       (tick),
        .running    (running),
        .div_pend   (div_pend)
    );

    always #5 master_clk = ~master_clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, got, exp);
        end
    endtask

    // Reference model: each channel is off / arming / running, with the edge index of its
    // last tick and of the edge at which the next tick is due; waveforms follow from those timestamps.
    int     init_div [3] = '{41667, 2604, 25000};
    int     mode     [3];
    longint last_e   [3];
    longint next_e   [3];
    int     cur_d    [3];
    int     shd_d    [3];
    logic   m_pend   [3];
    logic   m_tick   [3];
    longint n = 0;
    logic [2:0] e_clk, e_tick, e_run, e_pend;

    always @(posedge master_clk) begin
        n++;
        for (int c = 0; c < 3; c++) begin
            if (reset) begin
                mode[c] = 0; cur_d[c] = init_div[c]; shd_d[c] = init_div[c];
                m_pend[c] = 1'b0; m_tick[c] = 1'b0; last_e[c] = 0; next_e[c] = 0;
            end else begin
                logic w, applied;
                int   wv;
                w       = wr_en && (int'(wr_ch) == c);
                wv      = (int'(wr_div) < 2) ? 2 : int'(wr_div);
                applied = 1'b0;
                if (w) shd_d[c] = wv;
                m_tick[c] = 1'b0;
                if (!ch_en[c]) begin
                    if (mode[c] == 0) begin cur_d[c] = shd_d[c]; applied = 1'b1; end
                    mode[c] = 0;
                end else if (mode[c] == 0) begin
                    cur_d[c] = shd_d[c]; applied = 1'b1;
                    if (sync) begin
                        mode[c] = 2; last_e[c] = n; next_e[c] = n + cur_d[c]; m_tick[c] = 1'b1;
                    end else begin
                        mode[c] = 1; next_e[c] = n + cur_d[c] - 1;
                    end
                end else if (sync || n == next_e[c]) begin
                    cur_d[c] = shd_d[c]; applied = 1'b1;
                    mode[c] = 2; last_e[c] = n; next_e[c] = n + cur_d[c]; m_tick[c] = 1'b1;
                end
                m_pend[c] = applied ? 1'b0 : (w ? 1'b1 : m_pend[c]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            e_clk[c]  = (mode[c] == 2) && ((n - last_e[c]) < longint'(cur_d[c] - cur_d[c] / 2));
            e_tick[c] = m_tick[c];
            e_run[c]  = (mode[c] == 2);
            e_pend[c] = m_pend[c];
        end
        #1;
        check("clk_out",  32'(clk_out),  32'(e_clk));
        check("tick",     32'(tick),     32'(e_tick));
        check("running",  32'(running),  32'(e_run));
        check("div_pend", 32'(div_pend), 32'(e_pend));
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge master_clk);
    endtask

    task automatic wr(input int ch, input int d);
        @(negedge master_clk);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_div = 16'(d);
        @(negedge master_clk);
        wr_en = 1'b0;
    endtask

    task automatic set_en(input logic [2:0] v);
        @(negedge master_clk);
        ch_en = v;
    endtask

    task automatic capture(input int k, input int ch,
                           output logic [31:0] tk, output logic [31:0] ck, output logic [31:0] pd);
        tk = '0; ck = '0; pd = '0;
        for (int j = 0; j < k; j++) begin
            @(posedge master_clk);
            #1;
            tk[j] = tick[ch]; ck[j] = clk_out[ch]; pd[j] = div_pend[ch];
        end
    endtask

    initial begin
        logic [31:0] tk, ck, pd;
        @(posedge master_clk);
        #1;
        check("reset_outputs", 32'({clk_out, tick, running, div_pend}), 32'h0);
        cyc(2);
        reset = 1'b0;

        // ch0 divide by 4 from idle: first tick three edges after the enabling edge
        wr(0, 4);
        set_en(3'b001);
        capture(12, 0, tk, ck, pd);
        check("div4_tick", tk, 32'h888);
        check("div4_clk",  ck, 32'h998);

        // ch1 divide by 5: 3 high / 2 low, tick on each rising edge
        wr(1, 5);
        set_en(3'b011);
        capture(14, 1, tk, ck, pd);
        check("div5_tick", tk, 32'h210);
        check("div5_clk",  ck, 32'hE70);

        // divisor 0 clamps to 2
        set_en(3'b001);
        wr(1, 0);
        set_en(3'b011);
        capture(6, 1, tk, ck, pd);
        check("div0_tick", tk, 32'h2A);
        check("div0_clk",  ck, 32'h2A);
        wr(1, 1);
        cyc(10);

        // ch0 at 8, retarget to 3 mid-period: current period finishes at 8
        set_en(3'b010);
        wr(0, 8);
        set_en(3'b011);
        repeat (10) @(negedge master_clk);
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd3;
        @(posedge master_clk);
        #1;
        check("pend_after_write", 32'(div_pend[0]), 32'h1);
        @(negedge master_clk);
        wr_en = 1'b0;
        capture(10, 0, tk, ck, pd);
        check("retarget_tick", tk, 32'h090);
        check("retarget_pend", pd, 32'h00F);

        // divisors 4 and 6 out of phase, then realigned by sync
        set_en(3'b000);
        wr(0, 4);
        wr(1, 6);
        set_en(3'b001);
        cyc(3);
        set_en(3'b011);
        cyc(20);
        @(negedge master_clk);
        sync = 1'b1;
        @(posedge master_clk);
        #1;
        check("sync_tick", 32'(tick[1:0]),    32'h3);
        check("sync_clk",  32'(clk_out[1:0]), 32'h3);
        @(negedge master_clk);
        sync  = 1'b0;
        ch_en = 3'b010;
        @(posedge master_clk);
        #1;
        check("drop_en", 32'({clk_out[0], tick[0], running[0]}), 32'h0);
        cyc(14);
        set_en(3'b011);
        cyc(20);

        // enable and sync on the same edge: straight to RUN with a tick
        wr(2, 3);
        @(negedge master_clk);
        ch_en = 3'b111; sync = 1'b1;
        @(posedge master_clk);
        #1;
        check("en_sync_tick", 32'(tick[2]),    32'h1);
        check("en_sync_run",  32'(running[2]), 32'h1);
        @(negedge master_clk);
        sync = 1'b0;
        cyc(10);

        // out-of-range channel write must not disturb anything
        wr(3, 7);
        cyc(5);

        // asynchronous reset between edges
        @(negedge master_clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset", 32'({clk_out, tick, running, div_pend}), 32'h0);
        cyc(2);
        reset = 1'b0;
        cyc(2700);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge master_clk);
            for (int c = 0; c < 3; c++)
                if ($urandom_range(39) == 0) ch_en[c] = ~ch_en[c];
            wr_en  = ($urandom_range(9) == 0);
            wr_ch  = 2'($urandom_range(3));
            wr_div = 16'($urandom_range(12));
            sync   = ($urandom_range(49) == 0);
        end
        @(negedge master_clk);
        wr_en = 1'b0; sync = 1'b0;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
